// File: rtl/window_sum.sv
`default_nettype none
// ============================================================================
// Module   : window_sum
// Purpose  : Moving-window sum of the last DEPTH accepted unsigned samples,
//            with valid qualifier, synchronous clear and fill status.
//            Optional macro WINDOW_SUM_AVG_EN adds the registered avg output.
// Revision : 1.0 - initial release
// ============================================================================
module window_sum #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OUT_W = WIDTH + $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in,
    input  logic                       clear,
    output logic [OUT_W-1:0]           sum,
    output logic                       out_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef WINDOW_SUM_AVG_EN
    ,
    output logic [WIDTH-1:0]           avg
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [OUT_W-1:0] sum_q,  sum_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             vld_q,  vld_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        vld_d  = 1'b0;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wptr_d = '0;
            sum_d  = '0;
            cnt_d  = '0;
        end else if (in_valid) begin
            // Oldest entry is always part of sum_q, so the subtract cannot underflow.
            sum_d = sum_q + {{PTR_W{1'b0}}, in} - {{PTR_W{1'b0}}, mem_q[wptr_q]};
            mem_d[wptr_q] = in;
            wptr_d = wptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

`ifdef WINDOW_SUM_AVG_EN
    logic [WIDTH-1:0] avg_q;

    // Average tracks the new sum, so it is taken from sum_d rather than sum_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_q <= '0;
        end else begin
            avg_q <= sum_d[OUT_W-1:PTR_W];
        end
    end

    assign avg = avg_q;
`endif

    assign sum       = sum_q;
    assign out_valid = vld_q;
    assign count     = cnt_q;
    assign full      = (cnt_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_window_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_sum
// Purpose  : Self-checking bench for window_sum (table vectors, corner
//            sequences, randomized run against a queue-based window model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_sum;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OUT_W = WIDTH + $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_d;
    logic             clear;
    logic [OUT_W-1:0] sum;
    logic             out_valid;
    logic             full;
    logic [CNT_W-1:0] count;
`ifdef WINDOW_SUM_AVG_EN
    logic [WIDTH-1:0] avg;
`endif

    int n_chk;
    int n_fail;

    window_sum #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_d),
        .clear     (clear),
        .sum       (sum),
        .out_valid (out_valid),
        .full      (full),
        .count     (count)
`ifdef WINDOW_SUM_AVG_EN
        ,
        .avg       (avg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit c;
        int d;
        int s;
        bit ov;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, bit c, int d, int s, bit ov, int cnt);
        vec_t r;
        r.v = v; r.c = c; r.d = d; r.s = s; r.ov = ov; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int s, input bit ov, input int cnt);
        chk({tag, " sum"},       32'(sum),       32'(s));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " count"},     32'(count),     32'(cnt));
        chk({tag, " full"},      32'(full),      32'(cnt == DEPTH));
`ifdef WINDOW_SUM_AVG_EN
        chk({tag, " avg"},       32'(avg),       32'(s / DEPTH));
`endif
    endtask

    // Drive inputs, let one rising edge pass, then settle 1 time unit.
    task automatic step(input bit v, input bit c, input int d);
        in_valid = v;
        clear    = c;
        in_d     = WIDTH'(d);
        @(posedge clk);
        #1;
    endtask

    // Reference: keep the last DEPTH accepted samples in a queue and add them up.
    int hist[$];
    int m_sum;

    task automatic model(input bit v, input bit c, input int d, output bit ov);
        ov = 1'b0;
        if (c) begin
            hist.delete();
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            ov = 1'b1;
        end
        m_sum = 0;
        foreach (hist[i]) m_sum += hist[i];
    endtask

    initial begin
        bit ov;
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_d     = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 1'b0, 0);
        reset = 1'b0;

        // Basic window, idle hold, clear-with-valid, saturation, gap.
        tbl.push_back(mk(1, 0, 100, 100, 1, 1));
        tbl.push_back(mk(1, 0, 100, 200, 1, 2));
        tbl.push_back(mk(1, 0,   0, 200, 1, 3));
        tbl.push_back(mk(1, 0,  50, 250, 1, 4));
        tbl.push_back(mk(1, 0,  50, 200, 1, 4));
        tbl.push_back(mk(1, 0, 250, 350, 1, 4));
        tbl.push_back(mk(0, 0,  99, 350, 0, 4));
        tbl.push_back(mk(1, 1,  40,   0, 0, 0));
        tbl.push_back(mk(1, 0,   7,   7, 1, 1));
        tbl.push_back(mk(0, 1,   0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 255,  255, 1, 1));
        tbl.push_back(mk(1, 0, 255,  510, 1, 2));
        tbl.push_back(mk(1, 0, 255,  765, 1, 3));
        tbl.push_back(mk(1, 0, 255, 1020, 1, 4));
        tbl.push_back(mk(1, 0,   1,  766, 1, 4));
        tbl.push_back(mk(1, 0,   0,  511, 1, 4));
        tbl.push_back(mk(1, 0,   0,  256, 1, 4));
        tbl.push_back(mk(1, 0,   0,    1, 1, 4));
        tbl.push_back(mk(1, 0,   0,    0, 1, 4));
        tbl.push_back(mk(0, 1,   0,    0, 0, 0));
        tbl.push_back(mk(1, 0,  10,   10, 1, 1));
        tbl.push_back(mk(0, 0,  55,   10, 0, 1));
        tbl.push_back(mk(0, 0,  66,   10, 0, 1));
        tbl.push_back(mk(0, 0,  77,   10, 0, 1));
        tbl.push_back(mk(1, 0,  11,   21, 1, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d);
            check_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].ov, tbl[i].cnt);
        end

        // Asynchronous reset between edges after 10,11,12.
        step(0, 1, 0);
        step(1, 0, 10);
        step(1, 0, 11);
        step(1, 0, 12);
        check_all("pre-areset", 33, 1'b1, 3);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_all("areset", 0, 1'b0, 0);
        #1;
        reset = 1'b0;
        step(1, 0, 20);
        check_all("post-areset", 20, 1'b1, 1);

        // Randomized run against the window model.
        step(0, 1, 0);
        model(0, 1, 0, ov);
        for (int i = 0; i < 400; i++) begin
            bit v, c;
            int d;
            v = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 4);
            d = (($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)));
            step(v, c, d);
            model(v, c, d, ov);
            check_all($sformatf("rnd%0d", i), m_sum, ov, hist.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_sum.md
# window_sum

Parametrised moving-window accumulator: sums the last DEPTH accepted samples of an unsigned stream, with unaccepted history treated as zero. Generalises the fixed four-sample summer to any power-of-two window, adds a valid qualifier, a synchronous clear, and fill status. Sits in the datapath labs as the reusable smoothing/accumulation stage feeding comparators and display logic.

## Interface
- WIDTH, 8, sample width in bits (>=1)
- DEPTH, 4, window length in samples; power of two, >=2
- OUT_W, WIDTH+$clog2(DEPTH), sum width; derived, never overridden
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  sample qualifier; sample accepted on rising clk edge when high
- in  input  WIDTH  unsigned sample
- clear  input  1  synchronous clear, same effect as reset at next edge
- sum  output  OUT_W  sum of the last DEPTH accepted samples
- out_valid  output  1  one-cycle pulse, high the cycle after a sample is accepted
- full  output  1  high once DEPTH samples accepted since last reset/clear
- count  output  $clog2(DEPTH+1)  accepted samples since reset/clear, saturating at DEPTH

## Operation
- Storage: circular buffer of DEPTH x WIDTH entries, write pointer wptr ($clog2(DEPTH) bits), running-sum register, count register.
- Accept (in_valid=1, clear=0): sum <= sum + in - buf[wptr]; buf[wptr] <= in; wptr <= wptr+1 (wraps DEPTH-1 -> 0 naturally); count <= min(count+1, DEPTH); out_valid <= 1.
- Idle (in_valid=0, clear=0): all state held; out_valid <= 0.
- Clear (clear=1): buffer entries, sum, wptr, count, out_valid all <= 0; in_valid ignored that cycle (clear wins).
- Reset: identical state to clear, asynchronous, dominates clear and in_valid.
- Empty entries hold 0, so the first DEPTH-1 results are partial sums with zero-padded history.
- Arithmetic: unsigned, OUT_W wide; max DEPTH*(2^WIDTH-1) fits exactly, no overflow possible. Subtraction never underflows because subtracted entry is already included in sum.
- full = (count == DEPTH), combinational from count.

## Timing
- Reset values: sum=0, out_valid=0, full=0, count=0, all buffer entries 0, wptr=0.
- Latency: 1 cycle; sum reflects a sample from the edge that accepts it (registered, visible after that edge).
- out_valid high exactly one cycle per accepted sample; back-to-back accepts keep it high continuously.
- Reset asserted mid-window: outputs go to 0 immediately (no clock needed); first sample after release yields sum = that sample.
- Reset released: first accept on the next rising edge with reset low.
- count saturates: further accepts keep count=DEPTH, full=1.
- Clear and in_valid in the same cycle: result sum=0, count=0, out_valid=0.

## Configuration
- WINDOW_SUM_AVG_EN defined: extra output avg (input-width WIDTH) = sum >> $clog2(DEPTH), registered in the same edge as sum (computed from next sum, not the old one), reset/clear to 0; truncating division, always over DEPTH even while not full.
- Not defined: avg port and its register absent; all other behaviour identical.

## Test plan
- WIDTH=8, DEPTH=4; accepts 100,100,0,50,50,250 -> sum 100,200,200,250,200,350; out_valid high each following cycle; full from 4th accept.
- Saturation: after reset, 255 x4 then 0 x4 -> sum 255,510,765,1020,765,510,255,0; count stays 4; no wrap of sum.
- in_valid low for 3 cycles between accepts 10 and 11 -> sum holds 10, out_valid 0 during gap, then 21.
- reset asserted asynchronously between edges after 10,11,12 -> sum=0, count=0 before next edge; then accept 20 -> 20.
- clear=1 with in_valid=1, in=40 -> sum=0, count=0, out_valid=0; next accept 7 -> sum=7.
- With WINDOW_SUM_AVG_EN: 255 x4 -> avg 63,127,191,255; then 1 -> sum 766, avg 191.
